// File: rtl/reg_wb_sequencer_if.sv
// Token handshake and register-file write port of the write-back sequencer.
// The sequencer takes the slave modport; the producer/datapath side takes master.
interface reg_wb_sequencer_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_dat;

  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready,
    input  wr_en, wr_addr, wr_dat
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready,
    output wr_en, wr_addr, wr_dat
  );
endinterface

// File: rtl/reg_wb_sequencer.sv
// Write-back sequencer: buffers (addr, data) tokens and drains them onto the single register-file
// write port, zero-fills the file after reset or on request, and flags read-after-write hazards.
module reg_wb_sequencer #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_wb_sequencer_if.slave    bus,
  input  logic                 clr_req,
  input  logic                 wr_hold,
  input  logic [AW-1:0]        rd_addrA,
  input  logic [AW-1:0]        rd_addrB,
  output logic                 hazA,
  output logic                 hazB,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] CntLast = '1;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_pend_q, clr_pend_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_dat_q, wr_dat_d;

  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];

  logic empty, full, push, pop, in_ready;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = (state_q == StRun) && !clr_pend_q && !full;
  assign push     = bus.in_valid && in_ready;

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_dat   = wr_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (!wr_hold && cnt_q == CntLast) state_d = StRun;
      StRun:   if (clr_pend_q && empty) state_d = StClear;
      default: state_d = StClear;
    endcase
  end

  // Write-port loads, clear counter and pending-clear flag; wr_addr/wr_dat hold when idle.
  always_comb begin
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_dat_d   = wr_dat_q;
    pop        = 1'b0;
    unique case (state_q)
      StClear: begin
        if (!wr_hold) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_dat_d  = '0;
          cnt_d     = cnt_q + AW'(1);
        end
      end
      StRun: begin
        if (clr_pend_q && empty) begin
          cnt_d      = '0;
          clr_pend_d = 1'b0;
        end else begin
          if (clr_req) clr_pend_d = 1'b1;
          if (!wr_hold && !empty) begin
            pop       = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = fifo_addr[rptr_q];
            wr_dat_d  = fifo_data[rptr_q];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_dat_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_dat_q   <= wr_dat_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr_q] <= bus.in_addr;
      fifo_data[wptr_q] <= bus.in_data;
    end
  end

  always_comb begin
    hazA = (state_q == StClear) || (wr_en_q && wr_addr_q == rd_addrA);
    hazB = (state_q == StClear) || (wr_en_q && wr_addr_q == rd_addrB);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (fifo_addr[rptr_q + PW'(i)] == rd_addrA) hazA = 1'b1;
        if (fifo_addr[rptr_q + PW'(i)] == rd_addrB) hazB = 1'b1;
      end
    end
  end

  assign busy = (state_q == StClear) || clr_pend_q || !empty || wr_en_q;

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Self-checking bench: table vectors, hand sequences for clear/hold/reset, and random traffic
// compared each cycle against a queue-based reference model.
module tb_reg_wb_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_req = 1'b0;
  logic       wr_hold = 1'b0;
  logic [2:0] rd_addrA = '0;
  logic [2:0] rd_addrB = '0;
  logic       hazA, hazB, busy;

  always #5 clk = ~clk;

  reg_wb_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  reg_wb_sequencer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_req (clr_req),
    .wr_hold (wr_hold),
    .rd_addrA(rd_addrA),
    .rd_addrB(rd_addrB),
    .hazA    (hazA),
    .hazB    (hazB),
    .busy    (busy)
  );

  typedef struct packed {logic [2:0] a; logic [7:0] d;} tok_t;

  typedef struct {
    logic v; logic [2:0] a; logic [7:0] d; logic h; logic [2:0] ra; logic [2:0] rb;
    logic [15:0] exp;
  } vec_t;

  // Reference model state
  tok_t       m_q[$];
  bit         m_clearing;
  int         m_cnt;
  bit         m_pend;
  logic       m_wen;
  logic [2:0] m_waddr;
  logic [7:0] m_wdat;
  logic [7:0] m_rf[8];

  logic [7:0] dut_rf[8];
  int         wr_log[$];
  int         n_tests = 0;
  int         n_fail = 0;
  vec_t       vec[15];

  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      dut_rf[bus.wr_addr] <= bus.wr_dat;
      wr_log.push_back(int'(bus.wr_addr));
    end
  end

  function automatic logic [15:0] dut_out();
    return {bus.wr_en, bus.wr_addr, bus.wr_dat, bus.in_ready, hazA, hazB, busy};
  endfunction

  function automatic logic m_haz(input logic [2:0] ra);
    if (m_clearing) return 1'b1;
    if (m_wen && m_waddr == ra) return 1'b1;
    foreach (m_q[i]) if (m_q[i].a == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_ready();
    return !m_clearing && !m_pend && (m_q.size() < DEPTH);
  endfunction

  function automatic logic [15:0] m_expect(input logic [2:0] ra, input logic [2:0] rb);
    logic bz;
    bz = m_clearing || m_pend || (m_q.size() != 0) || m_wen;
    return {m_wen, m_waddr, m_wdat, m_ready(), m_haz(ra), m_haz(rb), bz};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_clearing = 1'b1;
    m_cnt = 0;
    m_pend = 1'b0;
    m_wen = 1'b0;
    m_waddr = '0;
    m_wdat = '0;
  endtask

  // One clock edge of the sequencer's rules, applied to the inputs sampled at that edge.
  task automatic model_step(input logic v, input logic [2:0] a, input logic [7:0] d,
                            input logic h, input logic c);
    bit   rdy;
    tok_t t;
    rdy = m_ready();
    if (m_wen) m_rf[m_waddr] = m_wdat;
    if (m_clearing) begin
      if (!h) begin
        m_wen = 1'b1;
        m_waddr = m_cnt[2:0];
        m_wdat = '0;
        if (m_cnt == 7) m_clearing = 1'b0;
        m_cnt++;
      end else begin
        m_wen = 1'b0;
      end
    end else if (m_pend && m_q.size() == 0) begin
      m_clearing = 1'b1;
      m_cnt = 0;
      m_pend = 1'b0;
      m_wen = 1'b0;
    end else begin
      if (c) m_pend = 1'b1;
      if (!h && m_q.size() > 0) begin
        t = m_q.pop_front();
        m_wen = 1'b1;
        m_waddr = t.a;
        m_wdat = t.d;
      end else begin
        m_wen = 1'b0;
      end
    end
    if (v && rdy) begin
      t.a = a;
      t.d = d;
      m_q.push_back(t);
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [2:0] a, input logic [7:0] d, input logic h,
                       input logic c, input bit use_exp, input logic [15:0] exp,
                       input string name);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    wr_hold      = h;
    clr_req      = c;
    #2;
    check(name, dut_out(), m_expect(rd_addrA, rd_addrB));
    if (use_exp) check({name, "_tbl"}, dut_out(), exp);
    @(posedge clk);
    model_step(v, a, d, h, c);
    #1;
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'h00, h, 1'b0, 1'b0, 16'h0, "idle");
  endtask

  task automatic check_rf(input string name);
    for (int i = 0; i < 8; i++) check(name, {8'h00, dut_rf[i]}, {8'h00, m_rf[i]});
  endtask

  task automatic check_clear_seq(input string name, input int first);
    check({name, "_len"}, 16'(wr_log.size()), 16'(first + 8));
    for (int i = 0; i < 8; i++) check(name, 16'(wr_log[first + i]), 16'(i));
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] a, input logic [7:0] d,
                              input logic h, input logic [2:0] ra, input logic [2:0] rb,
                              input logic wen, input logic [2:0] wa, input logic [7:0] wd,
                              input logic rdy, input logic ha, input logic hb, input logic bz);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.h = h; r.ra = ra; r.rb = rb;
    r.exp = {wen, wa, wd, rdy, ha, hb, bz};
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single token (rdA=3, rdB=5), then back-pressure with 4-deep queue (rdA=1, rdB=7).
    vec[0]  = mk(1, 3, 8'hA5, 0, 3, 5,  0, 7, 8'h00, 1, 0, 0, 0);
    vec[1]  = mk(0, 0, 8'h00, 0, 3, 5,  0, 7, 8'h00, 1, 1, 0, 1);
    vec[2]  = mk(0, 0, 8'h00, 0, 3, 5,  1, 3, 8'hA5, 1, 1, 0, 1);
    vec[3]  = mk(0, 0, 8'h00, 0, 3, 5,  0, 3, 8'hA5, 1, 0, 0, 0);
    vec[4]  = mk(1, 1, 8'h11, 1, 1, 7,  0, 3, 8'hA5, 1, 0, 0, 0);
    vec[5]  = mk(1, 2, 8'h22, 1, 1, 7,  0, 3, 8'hA5, 1, 1, 0, 1);
    vec[6]  = mk(1, 1, 8'h33, 1, 1, 7,  0, 3, 8'hA5, 1, 1, 0, 1);
    vec[7]  = mk(1, 7, 8'h77, 1, 1, 7,  0, 3, 8'hA5, 1, 1, 0, 1);
    vec[8]  = mk(1, 5, 8'h55, 1, 1, 7,  0, 3, 8'hA5, 0, 1, 1, 1);
    vec[9]  = mk(0, 0, 8'h00, 0, 1, 7,  0, 3, 8'hA5, 0, 1, 1, 1);
    vec[10] = mk(0, 0, 8'h00, 0, 1, 7,  1, 1, 8'h11, 1, 1, 1, 1);
    vec[11] = mk(0, 0, 8'h00, 0, 1, 7,  1, 2, 8'h22, 1, 1, 1, 1);
    vec[12] = mk(0, 0, 8'h00, 0, 1, 7,  1, 1, 8'h33, 1, 1, 1, 1);
    vec[13] = mk(0, 0, 8'h00, 0, 1, 7,  1, 7, 8'h77, 1, 0, 1, 1);
    vec[14] = mk(0, 0, 8'h00, 0, 1, 7,  0, 7, 8'h77, 1, 0, 0, 0);

    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    model_reset();
    #2;
    check("reset_vals", dut_out(), 16'h0007);

    // Reset release and initial clear
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_log.delete();
    idle(12, 1'b0);
    check_clear_seq("init_clear", 0);
    check_rf("init_rf");

    for (int i = 0; i < 15; i++) begin
      rd_addrA = vec[i].ra;
      rd_addrB = vec[i].rb;
      cycle(vec[i].v, vec[i].a, vec[i].d, vec[i].h, 1'b0, 1'b1, vec[i].exp, "tbl");
    end
    check("reg1_last", {8'h00, dut_rf[1]}, 16'h0033);
    check("reg3_val", {8'h00, dut_rf[3]}, 16'h00A5);
    check_rf("tbl_rf");

    // Clear with two queued tokens; the second arrives with clr_req
    rd_addrA = 3'd4;
    rd_addrB = 3'd6;
    cycle(1'b1, 3'd4, 8'h44, 1'b1, 1'b0, 1'b0, 16'h0, "clrq");
    cycle(1'b1, 3'd6, 8'h66, 1'b1, 1'b1, 1'b0, 16'h0, "clrq");
    check("clrq_ready_low", {15'h0, bus.in_ready}, 16'h0000);
    wr_log.delete();
    idle(16, 1'b0);
    check("clrq_tok0", 16'(wr_log[0]), 16'd4);
    check("clrq_tok1", 16'(wr_log[1]), 16'd6);
    check_clear_seq("clrq_clear", 2);
    check("clrq_reg4", {8'h00, dut_rf[4]}, 16'h0000);
    check("clrq_reg6", {8'h00, dut_rf[6]}, 16'h0000);

    // Hold during clear
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0, "hold_clr");
    idle(1, 1'b0);
    wr_log.delete();
    idle(3, 1'b0);
    idle(3, 1'b1);
    idle(10, 1'b0);
    check_clear_seq("hold_clear", 0);
    check_rf("hold_rf");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd_addrA = 3'($urandom_range(0, 7));
      rd_addrB = 3'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0), 1'b0, 16'h0, "rand");
    end
    idle(20, 1'b0);
    check_rf("rand_rf");

    // Reset with three tokens queued
    rd_addrA = 3'd2;
    rd_addrB = 3'd5;
    cycle(1'b1, 3'd2, 8'hC2, 1'b1, 1'b0, 1'b0, 16'h0, "rst_fill");
    cycle(1'b1, 3'd5, 8'hC5, 1'b1, 1'b0, 1'b0, 16'h0, "rst_fill");
    cycle(1'b1, 3'd6, 8'hC6, 1'b1, 1'b0, 1'b0, 16'h0, "rst_fill");
    bus.in_valid = 1'b0;
    wr_hold = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_vals", dut_out(), 16'h0007);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_log.delete();
    idle(14, 1'b0);
    check_clear_seq("rst_clear", 0);
    check_rf("rst_rf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wb_sequencer.md
# reg_wb_sequencer

Write-back sequencer that owns the single write port of the 8-register scratch file. It accepts (address, data) result tokens over a valid/ready handshake and buffers them in a small FIFO. It drains them one per cycle onto the file's write port (wr_en / wr_addr / data). After reset or on request, it zero-initialises every register, because the register file itself has no reset. It also reports read-after-write hazards for the two read addresses, so the datapath can stall while a write to that register is still pending.

## Interface
- DW, 8: data width
- AW, 3: register address width; the file has 2**AW entries
- DEPTH, 4: token FIFO depth (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  token offered
- in_ready  out  1  token accepted when in_valid && in_ready at a rising edge
- in_addr  in  AW  destination register
- in_data  in  DW  value to write
- clr_req  in  1  single-cycle pulse: zero all registers after draining
- wr_hold  in  1  write port borrowed; suppresses the write in the *following* cycle
- rd_addrA, rd_addrB  in  AW  addresses currently being read
- hazA, hazB  out  1  the matching read address has a pending write
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  AW  register-file write address (registered)
- wr_dat  out  DW  register-file write data (registered)
- busy  out  1  clearing, clear pending, FIFO non-empty, or wr_en high

## Operation
- State machine: CLEAR and RUN. Reset enters CLEAR with clear counter cnt=0.
- CLEAR:
  - At each rising edge with wr_hold=0, load wr_en=1, wr_addr=cnt, wr_dat=0, then increment cnt.
  - At an edge with wr_hold=1, load wr_en=0 and leave cnt unchanged.
  - On the edge that loads cnt=2**AW-1, move to RUN.
- RUN:
  - At each edge with wr_hold=0 and the FIFO non-empty, load the head into wr_addr/wr_dat, set wr_en=1, and pop.
  - Otherwise load wr_en=0. wr_addr and wr_dat hold their values when wr_en=0.
- Token order is preserved. Writes never merge or reorder, and duplicate addresses are written in order.
- in_ready = (state==RUN) && !clr_pend && !full. There is no pass-through when full: a pop and a push in the same cycle are only possible when the FIFO is not full.
- clr_req:
  - Sets clr_pend at the edge where it is sampled. in_ready falls in the next cycle.
  - A token accepted in the same cycle as clr_req is kept and written before the clear, so its register ends up at zero.
  - When RUN has the FIFO empty and clr_pend=1, the sequencer moves to CLEAR (cnt=0) and clears clr_pend. This transition edge does not load a FIFO entry.
  - clr_req during CLEAR is ignored.
- Hazards (combinational):
  - hazX=1 if any valid FIFO entry has addr==rd_addrX, or wr_en=1 with wr_addr==rd_addrX.
  - hazX is also 1 for every address while state==CLEAR.
- busy = (state==CLEAR) || clr_pend || !empty || wr_en.

## Timing
- Reset values while rst_n=0:
  - wr_en=0, wr_addr=0, wr_dat=0
  - in_ready=0, busy=1, hazA=hazB=1
  - FIFO empty, clr_pend=0
- Reset mid-operation: takes effect immediately and asynchronously. Queued tokens are dropped, and the clear restarts from cnt=0 after rst_n is released.
- Clear latency, with no hold: the first rising edge after rst_n is released loads the write to address 0. wr_en stays high for 2**AW consecutive cycles. in_ready=1 starting in the cycle after the last clear write is loaded.
- Token latency, with no hold and an empty FIFO:
  - Token accepted at edge N appears on wr_* after edge N+1.
  - The register file captures it at edge N+2.
  - Sustained throughput is one token per cycle.
- wr_hold in cycle C forces wr_en=0 in cycle C+1.
- FIFO pointers wrap modulo DEPTH. The count is width clog2(DEPTH)+1.

## Test plan
- **Reset and clear.** Release rst_n with wr_hold=0 → wr_en=1 for 8 cycles with wr_addr 0..7 and wr_dat=0. in_ready rises in the cycle after wr_addr=7 is loaded. busy falls once wr_en drops.
- **Single token.** Push (3, 0xA5) at edge N → after edge N+1, wr_en=1, wr_addr=3, wr_dat=0xA5. With rd_addrA=3, hazA is 1 from after edge N through the wr_en cycle, then 0. hazB with rd_addrB=5 stays 0.
- **Back-pressure.** Hold wr_hold=1 and push (1,0x11), (2,0x22), (1,0x33), (7,0x77) → in_ready=0 once 4 tokens are held. Release hold → four consecutive writes in order, and register 1 ends at 0x33.
- **Clear with queued tokens.** Queue two tokens under hold, pulse clr_req, release hold → both tokens are written, then 8 zero writes. in_ready=0 from the cycle after clr_req until clear completes.
- **Hold during clear.** wr_hold=1 for 3 cycles mid-clear → the address sequence pauses without skipping, and the clear still covers 0..7 exactly once.
- **Reset mid-stream.** Assert rst_n=0 with 3 tokens queued → outputs return to reset values immediately. After release, no queued token is written, and the clear restarts at address 0.
